// File: rtl/lisnoc_packetizer.sv
// LISNoC transmit adapter: turns a command plus payload words into a typed flit
// stream on one virtual channel, through a single output register.
module lisnoc_packetizer #(
   parameter int flit_data_width = 32,
   parameter int flit_type_width = 2,
   parameter int ph_dest_width   = 5,
   parameter int ph_prio_width   = 4,
   parameter int vchannels       = 1,
   parameter int len_width       = 4
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [ph_dest_width-1:0]                   req_dest,
   input  logic [ph_prio_width-1:0]                   req_prio,
   input  logic [len_width-1:0]                       req_len,
   input  logic [vchannels-1:0]                       req_vc,
   input  logic                                       req_valid,
   output logic                                       req_ready,
   input  logic [flit_data_width-1:0]                 data_word,
   input  logic                                       data_valid,
   output logic                                       data_ready,
   output logic [flit_data_width+flit_type_width-1:0] out_flit,
   output logic [vchannels-1:0]                       out_valid,
   input  logic [vchannels-1:0]                       out_ready,
   output logic                                       busy
);

   localparam int FW = flit_data_width + flit_type_width;

   localparam logic [flit_type_width-1:0] T_PAYLOAD = flit_type_width'(2'b00);
   localparam logic [flit_type_width-1:0] T_HEADER  = flit_type_width'(2'b01);
   localparam logic [flit_type_width-1:0] T_LAST    = flit_type_width'(2'b10);
   localparam logic [flit_type_width-1:0] T_SINGLE  = flit_type_width'(2'b11);

   typedef enum logic {IDLE, BODY} state_t;

   state_t                     state_q, state_d;
   logic [len_width-1:0]       rem_q, rem_d;
   logic                       occ_q, occ_d;
   logic [vchannels-1:0]       vc_q, vc_d;
   logic [FW-1:0]              flit_q, flit_d;
   logic [flit_data_width-1:0] hdr;
   logic                       drain, free, req_fire, data_fire;

   assign out_valid = occ_q ? vc_q : '0;
   assign out_flit  = flit_q;
   assign drain     = |(out_valid & out_ready);
   // Draining and refilling in the same cycle keeps the register full at 1 flit/cycle.
   assign free      = !occ_q | drain;
   assign req_fire  = req_valid & req_ready;
   assign data_fire = data_valid & data_ready;
   assign busy      = (state_q != IDLE) | occ_q;

   always_comb begin
      hdr = '0;
      hdr[flit_data_width-1 -: ph_dest_width] = req_dest;
      hdr[flit_data_width-ph_dest_width-1 -: ph_prio_width] = req_prio;
   end

   always_ff @(posedge clk) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_fire && req_len != '0) state_d = BODY;
         BODY:    if (data_fire && rem_q == len_width'(1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = rst & (state_q == IDLE) & free;
      data_ready = rst & (state_q == BODY) & free;
   end

   always_comb begin
      rem_d  = rem_q;
      occ_d  = occ_q;
      vc_d   = vc_q;
      flit_d = flit_q;
      if (drain) occ_d = 1'b0;
      if (req_fire) begin
         occ_d  = 1'b1;
         vc_d   = req_vc;
         rem_d  = req_len;
         flit_d = {(req_len == '0) ? T_SINGLE : T_HEADER, hdr};
      end else if (data_fire) begin
         occ_d  = 1'b1;
         rem_d  = rem_q - len_width'(1);
         flit_d = {(rem_q == len_width'(1)) ? T_LAST : T_PAYLOAD, data_word};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rem_q  <= '0;
         occ_q  <= 1'b0;
         vc_q   <= '0;
         flit_q <= '0;
      end else begin
         rem_q  <= rem_d;
         occ_q  <= occ_d;
         vc_q   <= vc_d;
         flit_q <= flit_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && req_fire) assert ($onehot(req_vc));
   end

endmodule

// File: tb/tb_lisnoc_packetizer.sv
// Directed and randomized bench for lisnoc_packetizer against a packet-level model
// that expands each accepted command/word into its expected flit.
module tb_lisnoc_packetizer;

   localparam int FW = 34;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [4:0]    req_dest;
   logic [3:0]    req_prio;
   logic [3:0]    req_len;
   logic [1:0]    req_vc;
   logic          req_valid;
   logic          req_ready;
   logic [31:0]   data_word;
   logic          data_valid;
   logic          data_ready;
   logic [FW-1:0] out_flit;
   logic [1:0]    out_valid;
   logic [1:0]    out_ready;
   logic          busy;

   lisnoc_packetizer #(
      .flit_data_width(32),
      .flit_type_width(2),
      .ph_dest_width(5),
      .ph_prio_width(4),
      .vchannels(2),
      .len_width(4)
   ) dut (
      .clk(clk), .rst(rst),
      .req_dest(req_dest), .req_prio(req_prio), .req_len(req_len), .req_vc(req_vc),
      .req_valid(req_valid), .req_ready(req_ready),
      .data_word(data_word), .data_valid(data_valid), .data_ready(data_ready),
      .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
   );

   typedef struct {
      logic [4:0] dest;
      logic [3:0] prio;
      logic [3:0] len;
      logic [1:0] vc;
   } cmd_t;

   typedef struct {
      logic [FW-1:0] flit;
      logic [1:0]    vc;
      int unsigned   cyc;
   } ent_t;

   cmd_t        cmd_q[$];
   logic [31:0] word_q[$];
   ent_t        exp_q[$];
   ent_t        out_log[$];
   logic [1:0]  rdy_seq[$];

   int unsigned rem_m;
   logic [1:0]  vc_m;
   int unsigned cyc;
   int          cmp_cnt;
   int          mis_cnt;
   int unsigned p_req, p_data, p_rdy;
   logic        rdy_toggle;
   logic        rst_val;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         mis_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic add_pkt(input logic [4:0] d, input logic [3:0] p, input logic [3:0] l,
                          input logic [1:0] v, input logic [31:0] first, input bit rnd);
      cmd_q.push_back('{dest: d, prio: p, len: l, vc: v});
      for (int i = 0; i < int'(l); i++)
         word_q.push_back(rnd ? $urandom : first + 32'(i));
   endtask

   task automatic drive();
      rst = rst_val;
      if (cmd_q.size() != 0 && $urandom_range(99) < p_req) begin
         req_valid = 1'b1;
         req_dest  = cmd_q[0].dest;
         req_prio  = cmd_q[0].prio;
         req_len   = cmd_q[0].len;
         req_vc    = cmd_q[0].vc;
      end else begin
         req_valid = 1'b0;
         req_dest  = 5'($urandom);
         req_prio  = 4'($urandom);
         req_len   = 4'($urandom);
         req_vc    = 2'($urandom);
      end
      if (word_q.size() != 0 && $urandom_range(99) < p_data) begin
         data_valid = 1'b1;
         data_word  = word_q[0];
      end else begin
         data_valid = 1'b0;
         data_word  = $urandom;
      end
      if (rdy_seq.size() != 0) out_ready = rdy_seq.pop_front();
      else if (rdy_toggle)     out_ready = ~out_ready;
      else begin
         out_ready[0] = ($urandom_range(99) < p_rdy);
         out_ready[1] = ($urandom_range(99) < p_rdy);
      end
   endtask

   task automatic observe();
      logic        drain_m, free_m, exp_rr, exp_dr;
      logic [1:0]  exp_ov;
      cmd_t        c;
      logic [31:0] w;
      exp_ov  = (exp_q.size() != 0) ? exp_q[0].vc : 2'b00;
      drain_m = (exp_q.size() != 0) && |(exp_q[0].vc & out_ready);
      free_m  = (exp_q.size() == 0) || drain_m;
      exp_rr  = rst && rem_m == 0 && free_m;
      exp_dr  = rst && rem_m != 0 && free_m;
      chk("out_valid", out_valid, exp_ov);
      if (exp_q.size() != 0) chk("out_flit", out_flit, exp_q[0].flit);
      chk("req_ready", req_ready, exp_rr);
      chk("data_ready", data_ready, exp_dr);
      chk("busy", busy, (rem_m != 0) || (exp_q.size() != 0));
      if (rst && |(out_valid & out_ready))
         out_log.push_back('{flit: out_flit, vc: out_valid, cyc: cyc});
      if (!rst) begin
         exp_q.delete();
         cmd_q.delete();
         word_q.delete();
         rem_m = 0;
      end else begin
         if (drain_m) void'(exp_q.pop_front());
         if (req_valid && exp_rr) begin
            c     = cmd_q.pop_front();
            rem_m = c.len;
            vc_m  = c.vc;
            exp_q.push_back('{flit: {(c.len == 0) ? 2'b11 : 2'b01, c.dest, c.prio, 23'd0},
                              vc: c.vc, cyc: 0});
         end
         if (data_valid && exp_dr) begin
            w = word_q.pop_front();
            exp_q.push_back('{flit: {(rem_m == 1) ? 2'b10 : 2'b00, w}, vc: vc_m, cyc: 0});
            rem_m--;
         end
      end
      cyc++;
   endtask

   task automatic cycle();
      drive();
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
   endtask

   task automatic run_until(input int n, input int budget, input string tag);
      while (out_log.size() < n && budget > 0) begin
         cycle();
         budget--;
      end
      chk(tag, out_log.size(), n);
   endtask

   initial begin
      logic [FW-1:0] ev[4];
      int unsigned   c0;
      int            total;
      logic [3:0]    l;
      cmp_cnt = 0; mis_cnt = 0; cyc = 0; rem_m = 0; vc_m = 2'b00;
      p_req = 100; p_data = 100; p_rdy = 100;
      rdy_toggle = 1'b0; out_ready = 2'b11;
      rst_val = 1'b0;
      drive();

      // reset state
      repeat (3) cycle();
      chk("rst_flit", out_flit, '0);
      chk("rst_valid", out_valid, 2'b00);
      rst_val = 1'b1;
      cycle();

      // single-flit packet
      out_log.delete();
      add_pkt(5'd5, 4'd3, 4'd0, 2'b01, 32'h0, 1'b0);
      run_until(1, 20, "t1_cnt");
      chk("t1_flit", out_log[0].flit, {2'b11, 5'd5, 4'd3, 23'd0});
      chk("t1_vc", out_log[0].vc, 2'b01);
      cycle();
      chk("t1_busy", busy, 1'b0);

      // three-word packet, no backpressure
      out_log.delete();
      add_pkt(5'd31, 4'd9, 4'd3, 2'b01, 32'hA, 1'b0);
      ev[0] = {2'b01, 5'd31, 4'd9, 23'd0};
      ev[1] = {2'b00, 32'hA};
      ev[2] = {2'b00, 32'hB};
      ev[3] = {2'b10, 32'hC};
      run_until(4, 30, "t2_cnt");
      for (int i = 0; i < 4; i++) begin
         chk("t2_flit", out_log[i].flit, ev[i]);
         if (i > 0) chk("t2_gap", out_log[i].cyc, out_log[i-1].cyc + 1);
      end

      // same packet with 4 cycles of backpressure on the header
      out_log.delete();
      c0 = cyc;
      repeat (5) rdy_seq.push_back(2'b00);
      add_pkt(5'd31, 4'd9, 4'd3, 2'b01, 32'hA, 1'b0);
      run_until(4, 30, "t3_cnt");
      chk("t3_hdr_cyc", out_log[0].cyc, c0 + 5);
      for (int i = 0; i < 4; i++) chk("t3_flit", out_log[i].flit, ev[i]);

      // back-to-back packets on different VCs
      out_log.delete();
      add_pkt(5'd1, 4'd1, 4'd1, 2'b01, 32'h11, 1'b0);
      add_pkt(5'd2, 4'd2, 4'd1, 2'b10, 32'h22, 1'b0);
      run_until(4, 30, "t4_cnt");
      chk("t4_last1", out_log[1].flit, {2'b10, 32'h11});
      chk("t4_hdr2", out_log[2].flit, {2'b01, 5'd2, 4'd2, 23'd0});
      chk("t4_vc2", out_log[2].vc, 2'b10);
      chk("t4_gap", out_log[2].cyc, out_log[1].cyc + 1);

      // reset in the middle of a long packet
      out_log.delete();
      add_pkt(5'd7, 4'd1, 4'd15, 2'b01, 32'h0, 1'b1);
      run_until(6, 40, "t5_cnt");
      rst_val = 1'b0;
      cycle();
      chk("t5_rr_in_rst", req_ready, 1'b0);
      cycle();
      chk("t5_valid", out_valid, 2'b00);
      chk("t5_busy", busy, 1'b0);
      chk("t5_flit", out_flit, '0);
      rst_val = 1'b1;
      out_log.delete();
      add_pkt(5'd3, 4'd4, 4'd0, 2'b10, 32'h0, 1'b0);
      run_until(1, 20, "t5b_cnt");
      chk("t5b_flit", out_log[0].flit, {2'b11, 5'd3, 4'd4, 23'd0});

      // maximum length with toggling ready
      out_log.delete();
      rdy_toggle = 1'b1;
      add_pkt(5'd12, 4'd5, 4'd15, 2'b01, 32'h0, 1'b1);
      run_until(16, 100, "t6_cnt");
      repeat (4) cycle();
      chk("t6_cnt_after", out_log.size(), 16);
      chk("t6_type0", out_log[0].flit[FW-1 -: 2], 2'b01);
      for (int i = 1; i < 15; i++) chk("t6_type_pay", out_log[i].flit[FW-1 -: 2], 2'b00);
      chk("t6_type_last", out_log[15].flit[FW-1 -: 2], 2'b10);
      chk("t6_busy", busy, 1'b0);
      rdy_toggle = 1'b0;

      // random traffic
      out_log.delete();
      p_req = 70; p_data = 70; p_rdy = 60;
      total = 0;
      repeat (40) begin
         l = 4'($urandom_range(0, 15));
         add_pkt(5'($urandom), 4'($urandom), l, ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01,
                 32'h0, 1'b1);
         total += int'(l) + 1;
      end
      run_until(total, 5000, "rnd_cnt");
      chk("rnd_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
      $finish;
   end

endmodule
